// File: rtl/int_source_arbiter.sv
// Expansion interrupt collector: synchronises N edge-triggered sources, latches them as pending,
// and exposes enable/status/round-robin cause/acknowledge registers on the 68000 bus.
module int_source_arbiter #(
    parameter int unsigned N    = 4,
    parameter logic [23:0] BASE = 24'hE90000
) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic [23:1]   ADDR,
    input  logic          AS_n,
    input  logic          UDS_n,
    input  logic          LDS_n,
    input  logic          RW,
    input  logic [15:0]   DIN,
    output logic [15:0]   DOUT,
    output logic          DOE,
    input  logic [N-1:0]  src,
    output logic          int_out
);

    logic [N-1:0] s1_q, s2_q, s3_q;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] enable_q, enable_d;
    logic [3:0]   rr_q, rr_d;
    logic         int_q, int_d;
    logic         wr_done_q, wr_done_d;
    logic         doe_q, doe_d;
    logic [15:0]  dout_q, dout_d;

    logic [N-1:0] rise, pe, ack_clr, gnt_oh;
    logic [3:0]   gnt_idx;
    logic         gnt_valid;
    logic         sel, wr_fire;
    logic [15:0]  rdata;
    logic [4:0]   target;
    logic         unused_din;

    assign unused_din = ^DIN;

    assign rise    = s2_q & ~s3_q;
    assign pe      = pending_q & enable_q;
    assign sel     = (ADDR[23:3] == BASE[23:3]) && !AS_n && (!UDS_n || !LDS_n);
    assign wr_fire = sel && !RW && !wr_done_q;
    assign ack_clr = (wr_fire && ADDR[2:1] == 2'd3) ? DIN[N-1:0] : '0;

    // Scan forward from rr_ptr, wrapping, for the first enabled pending source.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        target    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            target = {1'b0, rr_q} + 5'(k);
            if (target >= 5'(N)) target = target - 5'(N);
            for (int unsigned i = 0; i < N; i++) begin
                if (!gnt_valid && pe[i] && target == 5'(i)) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = 4'(i);
                    gnt_oh[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        unique case (ADDR[2:1])
            2'd0: begin
                rdata[N-1:0] = pending_q;
                rdata[15]    = int_q;
            end
            2'd1: rdata[N-1:0] = enable_q;
            2'd2: begin
                if (gnt_valid) begin
                    rdata[3:0] = gnt_idx;
                    rdata[15]  = 1'b1;
                end
            end
            default: rdata = '0;
        endcase
    end

    always_comb begin
        enable_d = enable_q;
        if (wr_fire && ADDR[2:1] == 2'd1) begin
            if (DIN[15]) enable_d = enable_q | DIN[N-1:0];
            else         enable_d = enable_q & ~DIN[N-1:0];
        end

        // A rise on the same edge as an acknowledge wins.
        pending_d = (pending_q & ~ack_clr) | rise;

        rr_d = rr_q;
        if (|(ack_clr & gnt_oh)) begin
            rr_d = (gnt_idx == 4'(N - 1)) ? 4'd0 : gnt_idx + 4'd1;
        end

        int_d = |pe;

        wr_done_d = wr_done_q;
        if (AS_n)         wr_done_d = 1'b0;
        else if (wr_fire) wr_done_d = 1'b1;

        doe_d  = doe_q;
        dout_d = dout_q;
        if (AS_n) begin
            doe_d  = 1'b0;
            dout_d = '0;
        end else if (sel && RW && !doe_q) begin
            doe_d  = 1'b1;
            dout_d = rdata;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            rr_q      <= '0;
            int_q     <= 1'b0;
            wr_done_q <= 1'b0;
            doe_q     <= 1'b0;
            dout_q    <= '0;
        end else begin
            s1_q      <= src;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            rr_q      <= rr_d;
            int_q     <= int_d;
            wr_done_q <= wr_done_d;
            doe_q     <= doe_d;
            dout_q    <= dout_d;
        end
    end

    assign DOUT    = dout_q;
    assign DOE     = doe_q;
    assign int_out = int_q;

endmodule
